ppa_brent_kung_pipe: RTL and testbench
======================================

Name: ppa_brent_kung_pipe

Overview:
Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor. It generalises the fixed 25-bit combinational prefix adder to any WIDTH and adds these features:
- configurable pipeline depth across the prefix levels;
- add/subtract mode;
- status flags;
- a valid/ready handshake.
It sits in the datapath wherever a wide adder must close timing at the system clock, for example in accumulators and address generators.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 4..64, any value (not only powers of two).
STAGES, 3, number of register ranks; latency in cycles; legal range 1..PREFIX_LEVELS+1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  operand beat offered.
in_ready  out  1  block can accept a beat this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in (add) or borrow-in (sub).
sub  in  1  0 = A+B+cin; 1 = A-B-cin.
out_valid  out  1  result beat present.
out_ready  in  1  downstream accepts the result.
sum  out  WIDTH  result.
cout  out  1  carry-out; in sub mode 1 = no borrow.
ovf  out  1  two's-complement signed overflow.
zero  out  1  sum == 0.

Behaviour:
- Reset and clocking: one clock domain; reset is synchronous and active-high. All state is cleared on a clk edge while rst=1.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, zero=0. All internal valid bits are 0.
- in_ready is 1 during reset deassertion.
- Operand preparation, combinational before rank 0:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - p = a ^ b_eff; g = a & b_eff.
- Prefix network:
  - Standard Brent-Kung up-sweep then down-sweep.
  - PREFIX_LEVELS = 2*ceil(log2(WIDTH)) - 1.
  - Group carries: c[i+1] = G[i:0] | (P[i:0] & c0).
  - Results: sum[i] = p[i] ^ c[i]; cout = c[WIDTH].
  - ovf = c[WIDTH] ^ c[WIDTH-1]; zero = (sum == 0).
- Pipeline placement:
  - Rank 0 registers the prepared p, g, c0 and sub.
  - The remaining STAGES-1 ranks sit after prefix level floor(k*PREFIX_LEVELS/STAGES), for k = 1..STAGES-1.
  - The final sum, flag and cout logic is combinational from the last rank.
  - Every rank carries a valid bit.
- Latency: a beat accepted on edge N gives out_valid=1 from edge N+STAGES-1 onward when unstalled. STAGES=1 therefore gives a result in the cycle after acceptance.
- Handshake:
  - Accept when in_valid & in_ready.
  - Global stall signal: stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stalled, all ranks hold, and sum/cout/ovf/zero/out_valid stay stable.
  - Bubbles propagate and are not squeezed out.
  - Throughput is 1 beat/cycle when out_ready=1.
- Simultaneous events:
  - Output consumed and new input accepted on the same edge is legal; the pipeline advances.
  - in_valid=0 inserts a bubble (valid=0). Bubble data fields are don't-care, but no X reaches a valid output.
- Reset mid-operation: all in-flight beats are discarded and out_valid=0 on the next cycle. No partial result is ever emitted.
- Ordering: strict FIFO order; no beat is dropped or duplicated.
- Odd WIDTH: missing prefix tree nodes are pass-through, so results are identical to a power-of-two tree truncated to WIDTH.

Decomposition:
- Shared package ppa_pkg holds:
  - function clog2;
  - function prefix_levels(width);
  - function stage_boundary(k, levels, stages);
  - typedef gp_t, a struct of P and G.
- One sub-module, bk_prefix_level, implements one Brent-Kung level with parameters WIDTH and LEVEL. It maps a gp vector to a gp vector, and the top generate-loops over levels, inserting ranks at the boundaries.

Test Plan:
- WIDTH=32, STAGES=3: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> after 2 edges, sum=0x00000000, cout=1, zero=1, ovf=0.
- Sub: a=5, b=7, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0, zero=0. Then a=7, b=5, cin=1, sub=1 -> sum=1, cout=1.
- Overflow: a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1, cout=0. Then a=0x80000000, b=1, sub -> sum=0x7FFFFFFF, ovf=1.
- Backpressure:
  - Stimulus: stream operands i+i for i=1..6 back-to-back; hold out_ready=0 for 3 cycles once the first result appears.
  - Required: in_ready=0 during the stall; sum holds at 2; results are then 2,4,6,8,10,12 in order with none lost.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 on the following cycle; no stale result ever appears; the next accepted beat has latency STAGES-1.
- Parameter sweep:
  - Configurations: WIDTH in {4,25,32,64} crossed with STAGES in {1, max}.
  - Stimulus: 10k random beats with random in_valid/out_ready.
  - Required: sum/cout/ovf/zero match the scoreboard model {cout,sum} = a +/- b +/- cin.

Source files
------------

// File: rtl/ppa_brent_kung_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined
// Brent-Kung prefix adder/subtractor.
package ppa_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } gp_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int prefix_levels(input int width);
    return 2 * clog2(width) - 1;
  endfunction

  function automatic int stage_boundary(
    input int k,
    input int levels,
    input int stages
  );
    return (k * levels) / stages;
  endfunction

  // True when a register rank follows prefix level `level`.
  function automatic bit rank_after(
    input int level,
    input int levels,
    input int stages
  );
    bit r;
    r = 1'b0;
    for (int k = 1; k < stages; k++)
      if (stage_boundary(k, levels, stages) == level)
        r = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ppa_brent_kung_pipe_if.sv
// Operand/result handshake bundle of the prefix adder.
// master drives operands and out_ready; slave is the adder.
interface ppa_brent_kung_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/ppa_brent_kung_pipe_bk_prefix_level.sv
// One Brent-Kung level: up-sweep levels first, then down-sweep.
// Nodes beyond WIDTH simply do not exist (pass-through tree).
module bk_prefix_level
  import ppa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEVEL = 0
) (
  input  gp_t [WIDTH-1:0] gp_i,
  output gp_t [WIDTH-1:0] gp_o
);
  localparam int LOGW = clog2(WIDTH);
  localparam bit UP   = (LEVEL < LOGW);
  localparam int EXP  = UP ? LEVEL : (2 * LOGW - 2 - LEVEL);
  localparam int SPAN = 1 << EXP;

  for (genvar i = 0; i < WIDTH; i++) begin : g_node
    localparam bit ACT = UP
      ? (((i + 1) % (2 * SPAN)) == 0)
      : ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 2 * SPAN));
    if (ACT) begin : g_op
      assign gp_o[i].g = gp_i[i].g
                       | (gp_i[i].p & gp_i[i-SPAN].g);
      assign gp_o[i].p = gp_i[i].p & gp_i[i-SPAN].p;
    end else begin : g_pass
      assign gp_o[i] = gp_i[i];
    end
  end
endmodule

// File: rtl/ppa_brent_kung_pipe.sv
// Pipelined Brent-Kung adder/subtractor with a global-stall
// valid/ready handshake and carry/overflow/zero flags.
module ppa_brent_kung_pipe
  import ppa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  ppa_brent_kung_pipe_if.slave bus
);
  localparam int LEVELS = prefix_levels(WIDTH);

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0_prep;
  gp_t  [WIDTH-1:0] gp_prep;

  gp_t  [WIDTH-1:0] gp_r0;
  logic [WIDTH-1:0] p_r0;
  logic             c0_r0;
  logic             v_r0;

  // Subtraction is A + ~B + ~borrow.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign c0_prep = bus.sub ? ~bus.cin : bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_prep
    assign gp_prep[i].p = bus.a[i] ^ b_eff[i];
    assign gp_prep[i].g = bus.a[i] & b_eff[i];
  end

  // Rank 0: capture prepared operands; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      gp_r0 <= '0;
      p_r0  <= '0;
      c0_r0 <= 1'b0;
      v_r0  <= 1'b0;
    end else if (!stall) begin
      gp_r0 <= gp_prep;
      p_r0  <= bus.a ^ b_eff;
      c0_r0 <= c0_prep;
      v_r0  <= bus.in_valid;
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    gp_t  [WIDTH-1:0] gp_i;
    gp_t  [WIDTH-1:0] gp_c;
    gp_t  [WIDTH-1:0] gp_o;
    logic [WIDTH-1:0] p_i;
    logic [WIDTH-1:0] p_o;
    logic             c0_i;
    logic             c0_o;
    logic             v_i;
    logic             v_o;

    if (l == 0) begin : g_head
      assign gp_i = gp_r0;
      assign p_i  = p_r0;
      assign c0_i = c0_r0;
      assign v_i  = v_r0;
    end else begin : g_link
      assign gp_i = g_lvl[l-1].gp_o;
      assign p_i  = g_lvl[l-1].p_o;
      assign c0_i = g_lvl[l-1].c0_o;
      assign v_i  = g_lvl[l-1].v_o;
    end

    bk_prefix_level #(
      .WIDTH(WIDTH),
      .LEVEL(l)
    ) u_level (
      .gp_i(gp_i),
      .gp_o(gp_c)
    );

    if (rank_after(l, LEVELS, STAGES)) begin : g_rank
      // Mid-tree rank: advance with the pipe, hold on stall.
      always_ff @(posedge clk) begin
        if (rst) begin
          gp_o <= '0;
          p_o  <= '0;
          c0_o <= 1'b0;
          v_o  <= 1'b0;
        end else if (!stall) begin
          gp_o <= gp_c;
          p_o  <= p_i;
          c0_o <= c0_i;
          v_o  <= v_i;
        end
      end
    end else begin : g_wire
      assign gp_o = gp_c;
      assign p_o  = p_i;
      assign c0_o = c0_i;
      assign v_o  = v_i;
    end
  end

  gp_t  [WIDTH-1:0] gp_f;
  logic [WIDTH-1:0] p_f;
  logic             c0_f;
  logic             v_f;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_raw;

  assign gp_f = g_lvl[LEVELS-1].gp_o;
  assign p_f  = g_lvl[LEVELS-1].p_o;
  assign c0_f = g_lvl[LEVELS-1].c0_o;
  assign v_f  = g_lvl[LEVELS-1].v_o;

  assign carry[0] = c0_f;
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign carry[i+1] = gp_f[i].g | (gp_f[i].p & c0_f);
  end
  assign sum_raw = p_f ^ carry[WIDTH-1:0];

  assign stall        = v_f & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // Outputs read as zero whenever no valid beat is present.
  assign bus.out_valid = v_f;
  assign bus.sum  = v_f ? sum_raw : '0;
  assign bus.cout = v_f & carry[WIDTH];
  assign bus.ovf  = v_f & (carry[WIDTH] ^ carry[WIDTH-1]);
  assign bus.zero = v_f & (sum_raw == '0);
endmodule

// File: tb/tb_ppa_brent_kung_pipe.sv
// Bench: directed cases on a 32/3 instance, plus a random
// scoreboard sweep over WIDTH x {1, max STAGES}.
module tb_ppa_brent_kung_pipe;

  typedef logic [127:0] word_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input word_t got,
    input word_t exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  ppa_brent_kung_pipe_if #(.WIDTH(32)) bus ();

  ppa_brent_kung_pipe #(
    .WIDTH(32),
    .STAGES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam int NB = 10000;
  localparam int WS[8] = '{4, 4, 25, 25, 32, 32, 64, 64};
  localparam int SS[8] = '{1, 4, 1, 10, 1, 10, 1, 12};

  for (genvar gi = 0; gi < 8; gi++) begin : g_sw
    localparam int W = WS[gi];
    localparam int S = SS[gi];

    logic srst;
    logic fin = 1'b0;
    ppa_brent_kung_pipe_if #(.WIDTH(W)) sbus ();

    ppa_brent_kung_pipe #(
      .WIDTH(W),
      .STAGES(S)
    ) u_dut (
      .clk(clk),
      .rst(srst),
      .bus(sbus)
    );

    function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      v = W'({$urandom, $urandom});
      case ($urandom_range(7))
        0: v = '0;
        1: v = '1;
        2: v = {1'b1, {(W-1){1'b0}}};
        3: v = {1'b0, {(W-1){1'b1}}};
        default: ;
      endcase
      return v;
    endfunction

    // {cout, ovf, zero, sum} from plain integer arithmetic.
    function automatic logic [W+2:0] model(
      input logic [W-1:0] x,
      input logic [W-1:0] y,
      input logic ci,
      input logic s
    );
      logic signed [W+2:0] sx, sy, r;
      logic [W:0] u, ye;
      logic co, ov;
      sx = {{3{x[W-1]}}, x};
      sy = {{3{y[W-1]}}, y};
      ye = {1'b0, y} + {{W{1'b0}}, ci};
      if (!s) begin
        u  = {1'b0, x} + ye;
        r  = sx + sy + {{(W+2){1'b0}}, ci};
        co = u[W];
      end else begin
        u  = {1'b0, x} - ye;
        r  = sx - sy - {{(W+2){1'b0}}, ci};
        co = ({1'b0, x} >= ye);
      end
      ov = (r[W+2:W-1] != {4{r[W-1]}});
      return {co, ov, (u[W-1:0] == '0), u[W-1:0]};
    endfunction

    initial begin
      logic [W+2:0] q[$];
      logic [W+2:0] e;
      int sent, recv, cyc;
      string tag;
      tag = $sformatf("sw%0d_w%0d_s%0d", gi, W, S);
      srst = 1'b1;
      sbus.in_valid = 1'b0;
      sbus.out_ready = 1'b0;
      sbus.a = '0;
      sbus.b = '0;
      sbus.cin = 1'b0;
      sbus.sub = 1'b0;
      repeat (2) @(negedge clk);
      srst = 1'b0;
      sent = 0;
      recv = 0;
      cyc = 0;
      while (recv < NB && cyc < NB * 8) begin
        @(negedge clk);
        sbus.in_valid  = (sent < NB) && ($urandom_range(3) != 0);
        sbus.a         = pick();
        sbus.b         = pick();
        sbus.cin       = 1'($urandom_range(1));
        sbus.sub       = 1'($urandom_range(1));
        sbus.out_ready = ($urandom_range(3) != 0);
        #1;
        if (sbus.in_valid && sbus.in_ready) begin
          q.push_back(model(sbus.a, sbus.b, sbus.cin, sbus.sub));
          sent++;
        end
        if (sbus.out_valid && sbus.out_ready) begin
          if (q.size() == 0) begin
            check({tag, "_extra"}, word_t'(1), word_t'(0));
          end else begin
            e = q.pop_front();
            check(tag, word_t'({sbus.cout, sbus.ovf,
                                sbus.zero, sbus.sum}),
                  word_t'(e));
          end
          recv++;
        end
        cyc++;
      end
      check({tag, "_count"}, word_t'(recv), word_t'(NB));
      fin = 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic run_one(
    input string tag,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic ci,
    input logic s,
    input logic [34:0] exp
  );
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = x;
    bus.b         = y;
    bus.cin       = ci;
    bus.sub       = s;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, word_t'(lat), word_t'(2));
    check(tag, word_t'({bus.cout, bus.ovf, bus.zero, bus.sum}),
          word_t'(exp));
  endtask

  initial begin
    int sent, got, stall_left, seen, cnt;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a   = '0;
    bus.b   = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset", word_t'({bus.in_ready, bus.out_valid, bus.cout,
                            bus.ovf, bus.zero, bus.sum}),
          word_t'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));

    run_one("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
            {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    run_one("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1,
            {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
    run_one("sub_bin", 32'd7, 32'd5, 1'b1, 1'b1,
            {1'b1, 1'b0, 1'b0, 32'h0000_0001});
    run_one("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
            {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    run_one("ovf_sub", 32'h8000_0000, 32'd1, 1'b0, 1'b1,
            {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF});

    idle(2);
    sent = 0;
    got = 0;
    seen = 0;
    stall_left = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid && seen == 0) begin
        seen = 1;
        stall_left = 3;
      end
      bus.out_ready = (stall_left == 0);
      bus.in_valid  = (sent < 6);
      bus.a   = 32'(sent + 1);
      bus.b   = 32'(sent + 1);
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      #1;
      if (stall_left > 0) begin
        check("bp_hold", word_t'({bus.in_ready, bus.out_valid,
                                  bus.sum}),
              word_t'({1'b0, 1'b1, 32'd2}));
        stall_left--;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        check("bp_order", word_t'(bus.sum),
              word_t'(2 * (got + 1)));
        got++;
      end
    end
    check("bp_count", word_t'(got), word_t'(6));
    bus.out_ready = 1'b1;

    idle(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 32'(100 + i);
      bus.b = 32'd0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_flush", word_t'(bus.out_valid), word_t'(0));
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("rst_stale", word_t'(cnt), word_t'(0));
    run_one("post_rst", 32'd40, 32'd2, 1'b1, 1'b0,
            {1'b0, 1'b0, 1'b0, 32'd43});

    wait (g_sw[0].fin && g_sw[1].fin && g_sw[2].fin &&
          g_sw[3].fin && g_sw[4].fin && g_sw[5].fin &&
          g_sw[6].fin && g_sw[7].fin);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
